// File: rtl/fa_bist_ctrl.sv
// Exhaustive self-test sequencer for a 1-bit full adder (a, b, cin -> sum, cout).
// Define FA_BIST_LOOP_EN to repeat clean passes and count them on pass_count.
module fa_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       tv_a,
  output logic       tv_b,
  output logic       tv_cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_vec
`ifdef FA_BIST_LOOP_EN
  ,
  output logic [7:0] pass_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_tv;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic       r_fv;
  logic [2:0] r_fvec;
`ifdef FA_BIST_LOOP_EN
  logic [7:0] r_pcnt;
`endif

  logic       w_exp_sum;
  logic       w_exp_cout;
  logic       w_mis;
  logic [3:0] w_err_nxt;
  logic       w_last;
  logic       w_clean;

  assign w_exp_sum  = r_idx[2] ^ r_idx[1] ^ r_idx[0];
  assign w_exp_cout = (r_idx[2] & r_idx[1]) |
                      (r_idx[2] & r_idx[0]) |
                      (r_idx[1] & r_idx[0]);

  // Either bit wrong counts as a single vector error.
  assign w_mis     = (dut_sum != w_exp_sum) |
                     (dut_cout != w_exp_cout);
  assign w_err_nxt = r_err + {3'b000, w_mis};
  assign w_last    = (r_idx == 3'd7);
  assign w_clean   = (w_err_nxt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_tv    <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_fv    <= 1'b0;
      r_fvec  <= 3'd0;
`ifdef FA_BIST_LOOP_EN
      r_pcnt  <= 8'd0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_APPLY;
            r_idx   <= 3'd0;
            r_tv    <= 3'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
            r_fv    <= 1'b0;
            r_fvec  <= 3'd0;
`ifdef FA_BIST_LOOP_EN
            r_pcnt  <= 8'd0;
`endif
          end
        end
        S_APPLY: begin
          r_state <= S_WAIT;
          r_cnt   <= LP_SETTLE_LD;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          r_err <= w_err_nxt;
          if (w_mis && !r_fv) begin
            r_fv   <= 1'b1;
            r_fvec <= r_idx;
          end
          if (!w_last) begin
            r_idx   <= r_idx + 3'd1;
            r_tv    <= r_idx + 3'd1;
            r_state <= S_APPLY;
          end
`ifdef FA_BIST_LOOP_EN
          else if (w_clean) begin
            if (r_pcnt != 8'hff) begin
              r_pcnt <= r_pcnt + 8'd1;
            end
            r_idx   <= 3'd0;
            r_tv    <= 3'd0;
            r_state <= S_APPLY;
          end
`endif
          else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_clean;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tv_a       = r_tv[2];
  assign tv_b       = r_tv[1];
  assign tv_cin     = r_tv[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fv;
  assign fail_vec   = r_fvec;
`ifdef FA_BIST_LOOP_EN
  assign pass_count = r_pcnt;
`endif

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Directed bench for fa_bist_ctrl with a fault-injectable adder model.
// Expected run results are queued at start and checked when done rises.
module tb_fa_bist_ctrl;

  typedef struct {
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int fault = 0;
  bit sel = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic rst1, start1, sum1, cout1;
  logic tva1, tvb1, tvc1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] fvec1;
  logic rst3, start3, sum3, cout3;
  logic tva3, tvb3, tvc3, busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] fvec3;
`ifdef FA_BIST_LOOP_EN
  logic [7:0] pc1, pc3;
`endif

  fa_bist_ctrl u_dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .dut_sum(sum1), .dut_cout(cout1),
    .tv_a(tva1), .tv_b(tvb1), .tv_cin(tvc1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1),
    .fail_vec(fvec1)
`ifdef FA_BIST_LOOP_EN
    , .pass_count(pc1)
`endif
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .start(start3),
    .dut_sum(sum3), .dut_cout(cout3),
    .tv_a(tva3), .tv_b(tvb3), .tv_cin(tvc3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_valid(fv3),
    .fail_vec(fvec3)
`ifdef FA_BIST_LOOP_EN
    , .pass_count(pc3)
`endif
  );

  // Adders under test; fault 1 = cout stuck-at-0, fault 2 = sum stuck-at-1.
  always_comb begin
    sum1  = (fault == 2) ? 1'b1 : (tva1 ^ tvb1 ^ tvc1);
    cout1 = (fault == 1) ? 1'b0 :
            ((tva1 & tvb1) | (tva1 & tvc1) | (tvb1 & tvc1));
    sum3  = (fault == 2) ? 1'b1 : (tva3 ^ tvb3 ^ tvc3);
    cout3 = (fault == 1) ? 1'b0 :
            ((tva3 & tvb3) | (tva3 & tvc3) | (tvb3 & tvc3));
  end

  logic [2:0] o_tv, o_fvec;
  logic [3:0] o_err;
  logic o_busy, o_done, o_pass, o_fv;
  always_comb begin
    o_tv   = sel ? {tva3, tvb3, tvc3} : {tva1, tvb1, tvc1};
    o_busy = sel ? busy3 : busy1;
    o_done = sel ? done3 : done1;
    o_pass = sel ? pass3 : pass1;
    o_err  = sel ? err3 : err1;
    o_fv   = sel ? fv3 : fv1;
    o_fvec = sel ? fvec3 : fvec1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tv"}, 32'(o_tv), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_pass"}, 32'(o_pass), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    chk({tag, "_fv"}, 32'(o_fv), 0);
    chk({tag, "_fvec"}, 32'(o_fvec), 0);
  endtask

  function automatic exp_t model(input int fm);
    exp_t e;
    logic [2:0] v;
    logic ts, tc, os, oc;
    e.err = 4'd0;
    e.fv = 1'b0;
    e.fvec = 3'd0;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      ts = v[2] ^ v[1] ^ v[0];
      tc = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      os = (fm == 2) ? 1'b1 : ts;
      oc = (fm == 1) ? 1'b0 : tc;
      if (os != ts || oc != tc) begin
        e.err++;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fvec = v;
        end
      end
    end
    e.pass = (e.err == 4'd0);
    return e;
  endfunction

  task automatic run(input string tag, input bit use3,
                     input int fm, input bit mid);
    int s = use3 ? 3 : 1;
    int n = 8 * (s + 2);
    exp_t e;
    sel = use3;
    fault = fm;
    q.push_back(model(fm));
    @(negedge clk);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      if (k == 0) begin
        chk({tag, "_clr_err"}, 32'(o_err), 0);
        chk({tag, "_clr_fv"}, 32'(o_fv), 0);
      end
      chk({tag, "_tv"}, 32'(o_tv), (k < n) ? k / (s + 2) : 7);
      chk({tag, "_busy"}, 32'(o_busy), (k < n) ? 1 : 0);
      chk({tag, "_done"}, 32'(o_done), (k < n) ? 0 : 1);
      if (mid && k == 4 * (s + 2)) begin
        if (use3) start3 = 1'b1; else start1 = 1'b1;
      end
    end
    e = q.pop_front();
    chk({tag, "_err"}, 32'(o_err), 32'(e.err));
    chk({tag, "_fv"}, 32'(o_fv), 32'(e.fv));
    chk({tag, "_fvec"}, 32'(o_fvec), 32'(e.fvec));
    chk({tag, "_pass"}, 32'(o_pass), 32'(e.pass));
  endtask

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    chk_idle("reset1");
    sel = 1'b1;
    chk_idle("reset3");
`ifdef FA_BIST_LOOP_EN
    chk("reset_pc", 32'(pc1), 0);
`endif
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    sel = 1'b0;
    chk_idle("idle_hold");

`ifndef FA_BIST_LOOP_EN
    run("clean", 1'b0, 0, 1'b0);
    run("busy_start", 1'b0, 0, 1'b1);
`endif
    run("cout_sa0", 1'b0, 1, 1'b0);
`ifndef FA_BIST_LOOP_EN
    run("restart", 1'b0, 0, 1'b0);
`endif
    run("sum_sa1", 1'b0, 2, 1'b0);

    // Abort during WAIT of vector 5.
    sel = 1'b0;
    fault = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 40 && o_tv != 3'd5; i++) @(negedge clk);
    chk("abort_reach_v5", 32'(o_tv), 5);
    @(negedge clk);
    chk("abort_in_wait", 32'(o_busy), 1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk_idle("abort");
    @(negedge clk);
    chk_idle("abort_idle");

`ifndef FA_BIST_LOOP_EN
    run("settle3", 1'b1, 0, 1'b0);
`else
    sel = 1'b0;
    fault = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk);
      if (k == 48) chk("loop_pc2", 32'(pc1), 2);
      if (k == 72) fault = 1;
      if (k == 95) chk("loop_busy", 32'(busy1), 1);
    end
    chk("loop_done", 32'(done1), 1);
    chk("loop_pc", 32'(pc1), 3);
    chk("loop_err", 32'(err1), 4);
    chk("loop_fvec", 32'(fvec1), 3);
    chk("loop_pass", 32'(pass1), 0);
    fault = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
